// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if
//   Data-bus interface between the memory stage (master) and the data
//   memory / cache (slave).
//
//   dreq_valid    master -> slave  request valid, held until dresp_addr_ok
//   dreq_addr     master -> slave  byte address (low bits not masked)
//   dreq_size     master -> slave  0=byte, 1=half, 2=word
//   dreq_strobe   master -> slave  byte write enables, 0 for loads
//   dreq_data     master -> slave  write data already replicated to all lanes
//   dresp_addr_ok slave  -> master request accepted this cycle
//   dresp_data_ok slave  -> master response (read data / write done) valid
//   dresp_data    slave  -> master raw 32-bit read word
// ---------------------------------------------------------------------------
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [1:0]        dreq_size;
    logic [3:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//   Pipeline memory stage sitting after execute. Captures one instruction
//   per in_valid/in_ready handshake, runs the data-bus transaction for loads
//   and stores (size, byte strobes, lane replication, load extract/extend),
//   detects misaligned accesses, and presents a registered result to
//   writeback with an out_valid/out_ready handshake.
//
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   handshake from execute
//   mem_op              1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW, else none
//   alu_out             effective address or arithmetic result
//   store_data          register value written by stores
//   rd_in               destination register
//   dbus                data-bus master port (see mem_access_if)
//   out_valid/out_ready handshake to writeback
//   rd_out, wen_out     destination register and its write enable
//   result_out          writeback value
//   adel_out, ades_out  misaligned load / misaligned store flags
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rd_in,
    mem_access_if.master      dbus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        rd_out,
    output logic              wen_out,
    output logic [DATA_W-1:0] result_out,
    output logic              adel_out,
    output logic              ades_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t     state;
    logic [3:0] op_q;   // op of the access in flight, selects extract mode
    logic [1:0] lo_q;   // address low bits, select the load lane
    logic [4:0] rd_q;

    // Decode of the instruction currently offered by execute.
    logic              in_load;
    logic              in_store;
    logic              in_misaligned;
    logic [1:0]        in_size;
    logic [3:0]        in_strobe;
    logic [DATA_W-1:0] in_wdata;
    logic              take;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement can leave a value unassigned and infer a latch.
        in_load   = 1'b0;
        in_store  = 1'b0;
        in_size   = SIZE_WORD;
        in_strobe = 4'b0000;
        in_wdata  = store_data;
        case (mem_op)
            OP_LB, OP_LBU: begin
                in_load = 1'b1;
                in_size = SIZE_BYTE;
            end
            OP_LH, OP_LHU: begin
                in_load = 1'b1;
                in_size = SIZE_HALF;
            end
            OP_LW: in_load = 1'b1;
            OP_SB: begin
                in_store  = 1'b1;
                in_size   = SIZE_BYTE;
                in_strobe = 4'b0001 << alu_out[1:0];
                in_wdata  = {4{store_data[7:0]}};
            end
            OP_SH: begin
                in_store  = 1'b1;
                in_size   = SIZE_HALF;
                in_strobe = alu_out[1] ? 4'b1100 : 4'b0011;
                in_wdata  = {2{store_data[15:0]}};
            end
            OP_SW: begin
                in_store  = 1'b1;
                in_strobe = 4'b1111;
            end
            default: ;
        endcase
        in_misaligned = (in_load || in_store) &&
                        ((in_size == SIZE_HALF && alu_out[0]) ||
                         (in_size == SIZE_WORD && alu_out[1:0] != 2'b00));
    end

    // Accepting while HOLD drains lets back-to-back ops run at full rate.
    assign in_ready = (state == S_IDLE) || (state == S_HOLD && out_ready);
    assign take     = in_valid && in_ready;

    // Byte/half lane selection and extension of the raw read word.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [3:0]        op,
        input logic [1:0]        lo,
        input logic [DATA_W-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   load_extract = {{(DATA_W-8){b[7]}}, b};
            OP_LBU:  load_extract = {{(DATA_W-8){1'b0}}, b};
            OP_LH:   load_extract = {{(DATA_W-16){h[15]}}, h};
            OP_LHU:  load_extract = {{(DATA_W-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

    // Loads write back the extracted value; stores complete with nothing
    // to write.
    logic              op_q_load;
    logic [DATA_W-1:0] resp_result;
    assign op_q_load   = (op_q >= OP_LB) && (op_q <= OP_LW);
    assign resp_result = op_q_load ? load_extract(op_q, lo_q, dbus.dresp_data)
                                   : '0;

    // NOTE: all state here is sequential and uses non-blocking assignments,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            op_q             <= '0;
            lo_q             <= '0;
            rd_q             <= '0;
            dbus.dreq_valid  <= 1'b0;
            dbus.dreq_addr   <= '0;
            dbus.dreq_size   <= '0;
            dbus.dreq_strobe <= '0;
            dbus.dreq_data   <= '0;
            out_valid        <= 1'b0;
            rd_out           <= '0;
            wen_out          <= 1'b0;
            result_out       <= '0;
            adel_out         <= 1'b0;
            ades_out         <= 1'b0;
        end else if (take) begin
            op_q <= mem_op;
            lo_q <= alu_out[1:0];
            rd_q <= rd_in;
            if (!in_load && !in_store) begin
                state      <= S_HOLD;
                out_valid  <= 1'b1;
                rd_out     <= rd_in;
                wen_out    <= 1'b1;
                result_out <= DATA_W'(alu_out);
                adel_out   <= 1'b0;
                ades_out   <= 1'b0;
            end else if (in_misaligned) begin
                // Faulting access: report it without touching the bus.
                state      <= S_HOLD;
                out_valid  <= 1'b1;
                rd_out     <= rd_in;
                wen_out    <= 1'b0;
                result_out <= '0;
                adel_out   <= in_load;
                ades_out   <= in_store;
            end else begin
                state            <= S_REQ;
                out_valid        <= 1'b0;
                dbus.dreq_valid  <= 1'b1;
                dbus.dreq_addr   <= alu_out;
                dbus.dreq_size   <= in_size;
                dbus.dreq_strobe <= in_strobe;
                dbus.dreq_data   <= in_wdata;
            end
        end else begin
            case (state)
                S_REQ: begin
                    // data_ok before addr_ok belongs to no request of ours.
                    if (dbus.dresp_addr_ok) begin
                        dbus.dreq_valid <= 1'b0;
                        if (dbus.dresp_data_ok) begin
                            state      <= S_HOLD;
                            out_valid  <= 1'b1;
                            rd_out     <= rd_q;
                            wen_out    <= op_q_load;
                            result_out <= resp_result;
                            adel_out   <= 1'b0;
                            ades_out   <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dbus.dresp_data_ok) begin
                        state      <= S_HOLD;
                        out_valid  <= 1'b1;
                        rd_out     <= rd_q;
                        wen_out    <= op_q_load;
                        result_out <= resp_result;
                        adel_out   <= 1'b0;
                        ades_out   <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//   Self-checking bench for mem_access. Directed scenarios plus randomized
//   operations; expected bus fields and results come from a behavioural
//   model of the load/store rules written with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mem_op;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rd_out;
    logic        wen_out;
    logic [31:0] result_out;
    logic        adel_out;
    logic        ades_out;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_if bus ();

    mem_access dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_op     (mem_op),
        .alu_out    (alu_out),
        .store_data (store_data),
        .rd_in      (rd_in),
        .dbus       (bus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_out     (rd_out),
        .wen_out    (wen_out),
        .result_out (result_out),
        .adel_out   (adel_out),
        .ades_out   (ades_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present one instruction for one cycle; it is taken on the next edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd);
        in_valid   = 1'b1;
        mem_op     = op;
        alu_out    = addr;
        store_data = sdata;
        rd_in      = rd;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Full single-instruction transaction with a responder that accepts
    // the request after a_dly cycles and returns data d_dly cycles later.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input int a_dly, input int d_dly,
                          input logic [31:0] rdata);
        bit          ld, st, mis;
        int          sz, lane;
        logic [31:0] v, eres, edata;
        logic [3:0]  estrb;
        bit          ewen;

        // Reference model of the access.
        ld   = (op >= 1 && op <= 5);
        st   = (op >= 6 && op <= 8);
        sz   = (op == 1 || op == 2 || op == 6) ? 0 :
               (op == 3 || op == 4 || op == 7) ? 1 : 2;
        lane = int'(addr % 4);
        mis  = (ld || st) && ((sz == 1 && addr % 2 != 0) || (sz == 2 && lane != 0));
        estrb = 4'b0000;
        edata = sdata;
        if (st) begin
            if (sz == 0) begin
                estrb = 4'(1 << lane);
                edata = (sdata & 32'hFF) * 32'h0101_0101;
            end else if (sz == 1) begin
                estrb = (lane >= 2) ? 4'b1100 : 4'b0011;
                edata = (sdata & 32'hFFFF) * 32'h0001_0001;
            end else begin
                estrb = 4'b1111;
            end
        end
        eres = 32'h0;
        ewen = 1'b0;
        if (!ld && !st) begin
            eres = addr;
            ewen = 1'b1;
        end else if (ld && !mis) begin
            ewen = 1'b1;
            if (sz == 0) begin
                v    = (rdata >> (8 * lane)) & 32'hFF;
                eres = (op == 1 && v >= 32'h80) ? v + 32'hFFFF_FF00 : v;
            end else if (sz == 1) begin
                v    = (rdata >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
                eres = (op == 3 && v >= 32'h8000) ? v + 32'hFFFF_0000 : v;
            end else begin
                eres = rdata;
            end
        end

        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        issue(op, addr, sdata, rd);

        if ((ld || st) && !mis) begin
            for (int i = 0; i <= a_dly; i++) begin
                check({tag, ".req_valid"}, 32'(bus.dreq_valid), 32'd1);
                check({tag, ".req_addr"}, bus.dreq_addr, addr);
                check({tag, ".req_size"}, 32'(bus.dreq_size), 32'(sz));
                check({tag, ".req_strobe"}, 32'(bus.dreq_strobe), 32'(estrb));
                if (st) check({tag, ".req_data"}, bus.dreq_data, edata);
                check({tag, ".req_stall"}, 32'({in_ready, out_valid}), 32'd0);
                if (i == a_dly) begin
                    bus.dresp_addr_ok = 1'b1;
                    bus.dresp_data_ok = (d_dly == 0);
                    bus.dresp_data    = rdata;
                end else begin
                    // Stray data_ok before acceptance must be ignored.
                    bus.dresp_addr_ok = 1'b0;
                    bus.dresp_data_ok = 1'($urandom_range(0, 1));
                    bus.dresp_data    = ~rdata;
                end
                @(negedge clk);
            end
            bus.dresp_addr_ok = 1'b0;
            bus.dresp_data_ok = 1'b0;
            for (int j = 1; j <= d_dly; j++) begin
                check({tag, ".wait_idle_bus"}, 32'({bus.dreq_valid, out_valid, in_ready}), 32'd0);
                bus.dresp_data_ok = (j == d_dly);
                bus.dresp_data    = rdata;
                @(negedge clk);
            end
            bus.dresp_data_ok = 1'b0;
        end else begin
            check({tag, ".no_req"}, 32'(bus.dreq_valid), 32'd0);
        end

        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, ".wen_out"}, 32'(wen_out), 32'(ewen));
        check({tag, ".adel"}, 32'(adel_out), 32'(mis && ld));
        check({tag, ".ades"}, 32'(ades_out), 32'(mis && st));
        if (!mis) check({tag, ".result"}, result_out, eres);

        // Writeback stalls one cycle, the result must hold.
        @(negedge clk);
        check({tag, ".hold_stable"}, result_out, mis ? result_out : eres);
        check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drain"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        reset             = 1'b1;
        in_valid          = 1'b0;
        mem_op            = '0;
        alu_out           = '0;
        store_data        = '0;
        rd_in             = '0;
        out_ready         = 1'b0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.outs", 32'({wen_out, adel_out, ades_out, rd_out}), 32'd0);
        check("reset.result", result_out, 32'd0);
        check("reset.dreq_valid", 32'(bus.dreq_valid), 32'd0);

        // Directed cases from the plan.
        run_op("nonmem", 4'd0, 32'h1234_5678, 32'h0, 5'd8, 0, 0, 32'h0);
        run_op("lb",     4'd1, 32'h0000_1003, 32'h0, 5'd3, 1, 0, 32'h80FF_0000);
        run_op("lhu",    4'd4, 32'h0000_1002, 32'h0, 5'd4, 3, 2, 32'h80FF_0000);
        run_op("sb",     4'd6, 32'h0000_2001, 32'hAABB_CCDD, 5'd0, 0, 1, 32'h0);
        run_op("lw_mis", 4'd5, 32'h0000_3002, 32'h0, 5'd5, 0, 0, 32'h0);
        run_op("sh_mis", 4'd7, 32'h0000_3001, 32'h1111_2222, 5'd6, 0, 0, 32'h0);
        run_op("op_nine",4'd9, 32'hCAFE_F00D, 32'h0, 5'd9, 0, 0, 32'h0);
        run_op("lh_neg", 4'd3, 32'h0000_0100, 32'h0, 5'd10, 0, 0, 32'h1234_F00F);

        // Reset while waiting for data; a late data_ok must not leak out.
        issue(4'd5, 32'h0000_4000, 32'h0, 5'd7);
        bus.dresp_addr_ok = 1'b1;
        @(negedge clk);
        bus.dresp_addr_ok = 1'b0;
        check("rst_wait.in_wait", 32'({bus.dreq_valid, in_ready}), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rst_wait.async", 32'({out_valid, in_ready, bus.dreq_valid}), 32'b010);
        @(negedge clk);
        reset             = 1'b0;
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.dresp_data_ok = 1'b0;
        check("rst_wait.stale_ignored", 32'({out_valid, in_ready}), 32'b01);
        run_op("lw_after_rst", 4'd5, 32'h0000_4000, 32'h0, 5'd7, 1, 1, 32'h1357_9BDF);

        // Back-to-back non-memory ops at one per cycle.
        begin
            logic [31:0] exp_q[$];
            logic [31:0] a;
            out_ready = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (k > 0) begin
                    check("b2b.valid", 32'(out_valid), 32'd1);
                    check("b2b.result", result_out, exp_q.pop_front());
                end
                a          = $urandom;
                exp_q.push_back(a);
                in_valid   = 1'b1;
                mem_op     = 4'd0;
                alu_out    = a;
                rd_in      = 5'(k + 1);
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("b2b.last", result_out, exp_q.pop_front());
            @(negedge clk);
            check("b2b.drain", 32'(out_valid), 32'd0);
            out_ready = 1'b0;
        end

        // Randomized operations.
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            op   = 4'($urandom_range(0, 10));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_op($sformatf("rnd%0d", n), op, addr, $urandom, 5'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage.
- Takes the ALU result (effective address or arithmetic result), the store data and the destination register from execute.
- Runs the data-bus transaction for loads and stores: byte strobes, size, and load extract/extend.
- Hands a registered result to writeback with a valid/ready handshake and stalls the pipeline while the bus is busy.

Parameters:
- ADDR_W, 32, width of the data-bus address and of alu_out.
- DATA_W, 32, width of store and load data. Only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- mem_op  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; other codes are treated as none.
- alu_out  in  ADDR_W  ALU result / effective address.
- store_data  in  DATA_W  rt value for stores.
- rd_in  in  5  destination register.
- dreq_valid  out  1  bus request.
- dreq_addr  out  ADDR_W  request address.
- dreq_size  out  2  0=byte, 1=half, 2=word.
- dreq_strobe  out  4  byte write enables; 0 for loads.
- dreq_data  out  DATA_W  lane-shifted write data.
- dresp_addr_ok  in  1  request accepted.
- dresp_data_ok  in  1  response valid.
- dresp_data  in  DATA_W  raw read word.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts.
- rd_out  out  5  destination register.
- wen_out  out  1  register write enable.
- result_out  out  DATA_W  writeback value.
- adel_out  out  1  misaligned load.
- ades_out  out  1  misaligned store.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All outputs 0, except in_ready=1.
  - Any in-flight bus transaction is abandoned; the response logic must ignore a late data_ok until a new request is issued.
- States: IDLE, REQ, WAIT, HOLD.
- in_ready=1 only in IDLE, or in HOLD when out_ready=1.
- A transfer occurs on in_valid && in_ready. It registers mem_op, alu_out, store_data and rd_in.
- Misalignment check at capture:
  - half with addr[0]=1, or word with addr[1:0]!=0.
  - Load → adel_out=1; store → ades_out=1.
  - No bus request is issued; wen_out=0; go to HOLD.
- Non-memory op:
  - go to HOLD next cycle with result_out=alu_out, wen_out=1 (1-cycle latency).
  - rd_out=0 still asserts wen_out; the register file ignores r0.
- Aligned load/store: go to REQ.
- REQ:
  - dreq_valid=1; dreq_addr = registered address with bits [1:0] passed unmasked.
  - dreq_size from op.
  - Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011 or 4'b1100 by addr[1]; SW 4'b1111.
  - Store data: SB byte replicated ×4, SH half replicated ×2, SW unchanged.
  - dreq_* stay stable until addr_ok.
  - addr_ok && data_ok same cycle → HOLD. addr_ok only → WAIT.
- WAIT: dreq_valid=0; on data_ok → HOLD.
- Load extract in the cycle data_ok is seen:
  - select byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - wen_out=1.
- Stores: wen_out=0, result_out=0.
- HOLD:
  - out_valid=1; result/rd/wen/exception outputs held stable.
  - On out_ready, if a new transfer happens the same cycle (back-to-back), go to its next state directly. Otherwise go to IDLE and drop out_valid.
- out_valid is registered; it never depends combinationally on out_ready.
- data_ok in IDLE/REQ-before-addr_ok/HOLD is ignored.
- Throughput:
  - 1 instr/cycle for back-to-back non-memory ops with out_ready=1.
  - Memory ops take ≥2 cycles.

Test Plan:
- Non-memory op, alu_out=0x1234_5678, rd_in=8, out_ready=1 → next cycle out_valid=1, result_out=0x12345678, wen_out=1, rd_out=8; no dreq_valid.
- LB at 0x1003, dresp_data=0x80FF_0000, addr_ok+data_ok 1 cycle after REQ, in the same cycle → result_out=0xFFFF_FF80, wen_out=1.
- LHU at 0x1002 with dresp_data=0x80FF_0000; addr_ok delayed 3 cycles, then data_ok 2 cycles later → dreq fields stable throughout REQ; result_out=0x0000_80FF; in_ready=0 until HOLD.
- SB at 0x2001, store_data=0xAABB_CCDD → dreq_strobe=4'b0010, dreq_data=0xDDDD_DDDD, dreq_size=0; completes with wen_out=0.
- LW at 0x3002 → adel_out=1, dreq_valid never asserted, wen_out=0. SH at 0x3001 → ades_out=1, dreq_valid never asserted, wen_out=0.
- Assert reset during WAIT, then issue a new LW; a late data_ok arrives before the new REQ → state=IDLE and out_valid=0 immediately; the stale data_ok is ignored; the new LW returns correct data.
